// File: rtl/pipe_ctrl_if.sv
// Handshake and stage-control bundle between a pipeline controller and its
// surroundings. The occ signal exists only when PIPE_CTRL_OCC_EN is defined.
interface pipe_ctrl_if #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned CW     = 5
);

  logic              in_valid;
  logic              in_ready;
  logic              out_ready;
  logic              out_valid;
  logic [STAGES-1:0] stage_en;
  logic [STAGES-1:0] stage_vld;
`ifdef PIPE_CTRL_OCC_EN
  logic [CW-1:0]     occ;
`endif

`ifdef PIPE_CTRL_OCC_EN
  // Upstream/downstream side: offers operands, accepts results.
  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  stage_en,
    input  stage_vld,
    input  occ
  );

  // Controller side.
  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output stage_en,
    output stage_vld,
    output occ
  );
`else
  // Upstream/downstream side: offers operands, accepts results.
  modport master (
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  stage_en,
    input  stage_vld
  );

  // Controller side.
  modport slave (
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_valid,
    output stage_en,
    output stage_vld
  );
`endif

endinterface

// File: rtl/pipe_ctrl.sv
// Valid/enable controller for a chain of STAGES enabled pipeline registers.
// Each stage advances when it is empty or when its successor advances, so
// bubbles collapse and only stages behind a full, blocked successor stall.
// State is updated on the falling edge of clk to match the stage registers.
// Optional build macro PIPE_CTRL_OCC_EN adds a registered occupancy count.
module pipe_ctrl #(
  parameter int unsigned STAGES = 4,
  parameter int unsigned CW     = 5
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     flush,
  pipe_ctrl_if.slave bus
);

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] v_d;
  logic [STAGES-1:0] en;
  logic [STAGES-1:0] v_src;

  // Source of each stage's valid bit: stage 0 takes in_valid, others take
  // their predecessor.
  if (STAGES == 1) begin : g_src_one
    assign v_src = bus.in_valid;
  end else begin : g_src_multi
    assign v_src = {v_q[STAGES-2:0], bus.in_valid};
  end

  // Enable chain, walked from the output end back towards the input.
  always_comb begin
    logic chain;
    en    = '0;
    chain = bus.out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      chain = ~v_q[i] | chain;
      en[i] = chain;
    end
  end

  // Next valid state: enabled stages load from their source, flush wins.
  always_comb begin
    v_d = (en & v_src) | (~en & v_q);
    if (flush) begin
      v_d = '0;
    end
  end

  // Valid-bit register, falling-edge with asynchronous active-low clear.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      v_q <= '0;
    end else begin
      v_q <= v_d;
    end
  end

  // Outputs are pure functions of state and out_ready.
  always_comb begin
    bus.stage_en  = en;
    bus.stage_vld = v_q;
    bus.in_ready  = en[0];
    bus.out_valid = v_q[STAGES-1];
  end

`ifdef PIPE_CTRL_OCC_EN
  logic [CW-1:0] occ_q;
  logic [CW-1:0] occ_d;
  logic          accept;
  logic          consume;

  assign accept  = bus.in_valid & en[0];
  assign consume = v_q[STAGES-1] & bus.out_ready;

  // Track popcount(v) incrementally from the entry and exit events.
  always_comb begin
    occ_d = occ_q;
    if (flush) begin
      occ_d = '0;
    end else if (accept && !consume) begin
      occ_d = occ_q + CW'(1);
    end else if (!accept && consume) begin
      occ_d = occ_q - CW'(1);
    end
  end

  // Occupancy register, same clocking and reset as the valid bits.
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign bus.occ = occ_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with STAGES=4: a vector table for the
// cycle-by-cycle valid/enable behaviour, plus hand sequences for latency,
// streaming, asynchronous reset and reset discarding in-flight operands.
module tb_pipe_ctrl;

  localparam int unsigned STAGES = 4;
  localparam int unsigned CW     = 5;

  logic clk;
  logic reset;
  logic flush;

  pipe_ctrl_if #(.STAGES(STAGES), .CW(CW)) bus ();

  pipe_ctrl #(.STAGES(STAGES), .CW(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present inputs just after the rising edge, well away from the active edge.
  task automatic drive(input logic iv, input logic orr, input logic fl);
    @(posedge clk);
    bus.in_valid  = iv;
    bus.out_ready = orr;
    flush         = fl;
  endtask

  typedef struct {
    logic       iv;
    logic       orr;
    logic       fl;
    logic [3:0] en;    // stage_en before the edge
    logic [3:0] post;  // stage_vld after the edge
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  logic [3:0] exp_v;
  int         first_hi;
  int         hi_cnt;

  initial begin
    // Fill, full stall, consume+accept, flush.
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 4'b0001};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 4'b0011};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 4'b0111};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 4'b1111};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 4'b0000, 4'b1111};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 4'b1111, 4'b0000};
    // Bubble insertion and collapse behind a blocked output.
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 4'b0001};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b0010};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 4'b1111, 4'b0101};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 4'b1111, 4'b1010};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 4'b0111, 4'b1100};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 4'b0011, 4'b1100};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 4'b0011, 4'b1101};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 4'b1111, 4'b1010};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 4'b1111, 4'b0101};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 4'b1111, 4'b1011};

    reset         = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state.
    #3;
    chk("rst_stage_vld", 32'(bus.stage_vld), 32'h0);
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_stage_en", 32'(bus.stage_en), 32'hf);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
`ifdef PIPE_CTRL_OCC_EN
    chk("rst_occ", 32'(bus.occ), 32'h0);
`endif
    @(posedge clk);
    #2 reset = 1'b1;

    // Table-driven vectors.
    exp_v = 4'b0000;
    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].iv, vecs[i].orr, vecs[i].fl);
      #1;
      chk($sformatf("v%0d_stage_en", i), 32'(bus.stage_en), 32'(vecs[i].en));
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].en[0]));
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(exp_v[3]));
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_stage_vld", i), 32'(bus.stage_vld), 32'(vecs[i].post));
`ifdef PIPE_CTRL_OCC_EN
      chk($sformatf("v%0d_occ", i), 32'(bus.occ), 32'($countones(vecs[i].post)));
`endif
      exp_v = vecs[i].post;
    end

    // Asynchronous reset between edges with v=1011.
    #2 reset = 1'b0;
    #1;
    chk("arst_stage_vld", 32'(bus.stage_vld), 32'h0);
    chk("arst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("arst_stage_en", 32'(bus.stage_en), 32'hf);
    chk("arst_in_ready", 32'(bus.in_ready), 32'h1);
`ifdef PIPE_CTRL_OCC_EN
    chk("arst_occ", 32'(bus.occ), 32'h0);
`endif
    bus.in_valid = 1'b0;
    #1 reset = 1'b1;

    // Single-operand latency: out_valid only after the 4th edge.
    for (int k = 1; k <= 6; k++) begin
      drive(k == 1, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      chk($sformatf("lat_e%0d_out_valid", k), 32'(bus.out_valid), 32'(k == 4));
    end

    // Streaming 10 operands with out_ready held high.
    first_hi = 0;
    hi_cnt   = 0;
    for (int k = 1; k <= 14; k++) begin
      drive(k <= 10, 1'b1, 1'b0);
      #1;
      chk($sformatf("str_e%0d_in_ready", k), 32'(bus.in_ready), 32'h1);
      @(negedge clk);
      #1;
      chk($sformatf("str_e%0d_out_valid", k), 32'(bus.out_valid),
          32'(k >= 4 && k <= 13));
      if (bus.out_valid === 1'b1) begin
        hi_cnt++;
        if (first_hi == 0) first_hi = k;
      end
    end
    chk("str_first_out_edge", 32'(first_hi), 32'd4);
    chk("str_out_count", 32'(hi_cnt), 32'd10);

    // Reset mid-operation must discard in-flight operands.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      @(negedge clk);
    end
    #1;
    chk("mid_pre_stage_vld", 32'(bus.stage_vld), 32'h7);
    #2 reset = 1'b0;
    #1 reset = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      drive(1'b0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      chk($sformatf("mid_e%0d_out_valid", k), 32'(bus.out_valid), 32'h0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: timeout got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
